// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART definitions: FSM encodings, frame constants, divider helpers
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Same divider arithmetic as the transmitter so a loopback stays bit-exact.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half(input int clk_freq, input int baud_rate);
    return (clk_freq / baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// rtl/uart_rx_sync_2ff.sv - generic two-flop synchronizer with programmable reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, one-cycle valid/frame_err strobes
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV  = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int HALF = calc_half(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic        w_rx_s;
  uart_state_t r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= 16'd0;
            busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_M1) begin
            // A high line at mid-start is a glitch, not a frame.
            if (w_rx_s) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state   <= ST_DATA;
              r_cnt     <= 16'd0;
              r_bit_idx <= 3'd0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (r_cnt == DIV_M1) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_cnt   <= 16'd0;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
          if (r_cnt == DIV_M1) begin
            if (w_rx_s) begin
              data  <= r_shift;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Receives 8N1 asynchronous serial frames on `rx`: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Presents each byte on a parallel bus with a one-cycle strobe.
- Receive-side counterpart of `uart_tx`. Shares the same clock, CLK_FREQ/BAUD_RATE parameters and bit ordering, so a `uart_tx` → `uart_rx` loopback is bit-exact.
- Sits between the board RX pin and the command/data consumers in the fabric.

## Interface

Parameters:
- CLK_FREQ, 25000000, clock frequency in Hz.
- BAUD_RATE, 9600, line rate in baud.
- Derived: DIV = CLK_FREQ/BAUD_RATE (integer division, 2604 at defaults). HALF = DIV/2. Requirement: DIV ≥ 4.

Ports:
- clk  in  1  main clock. One clock domain only.
- rst_n  in  1  reset. Asynchronous, active-low.
- rx  in  1  serial line. Asynchronous to clk; idles high.
- data  out  8  last correctly framed byte. Held until the next good frame.
- valid  out  1  one-cycle pulse: `data` has just been updated.
- frame_err  out  1  one-cycle pulse: stop bit sampled low; byte discarded.
- busy  out  1  high while a frame is in progress (any state other than IDLE).

## Operation

- **Input synchronizer:** `rx` passes through 2 flops to give rx_s. Both flops reset to 1. All decisions use rx_s only.
- **Counter:** 16-bit baud counter, bit index 0..7, 8-bit shift register.
- **FSM: IDLE, START, DATA, STOP.**
  - IDLE: rx_s==0 → go to START, clear counter.
  - START: when counter==HALF-1, sample rx_s.
    - rx_s==1: glitch/false start → IDLE. No outputs.
    - rx_s==0: clear counter, bit index=0 → DATA.
  - DATA: when counter==DIV-1, sample rx_s into shift register MSB, shifting right. After 8 samples the first bit received is data[0]. On bit index 7 → STOP. Otherwise increment bit index. Counter clears on each sample.
  - STOP: when counter==DIV-1, sample rx_s.
    - rx_s==1: data<=shift register; valid pulses.
    - rx_s==0: frame_err pulses; data unchanged.
    - Either way → IDLE in the same cycle.
- Sampling points therefore land at mid-bit ±1 clock.
- **Back-to-back frames:**
  - Returning to IDLE at mid-stop allows a start edge ½ bit later to be caught.
  - A line stuck low after a frame_err restarts reception immediately (break condition produces repeated frame_err).
- **No handshake:** the consumer must capture `data` on `valid`. A new frame overwrites `data` without a flag.
- **Reset mid-frame:** async clear, FSM→IDLE, partial byte lost. The first frame after deassertion is received normally only if the start edge occurs ≥2 cycles after rst_n rises.

## Timing

- **Reset values:** data=8'h00, valid=0, frame_err=0, busy=0, FSM=IDLE, counter=0, synchronizer=2'b11.
- **Start-edge latency:** rx falling at cycle t is seen in IDLE at t+2. busy rises at t+3.
- **Output latency:** valid/frame_err are registered and assert the cycle after the stop sample, ≈ 2 + HALF + 9·DIV cycles after the start edge. They are exactly 1 cycle wide and never both high.
- busy falls in the same cycle valid/frame_err rises.
- **Counter width:** DIV up to 65535 supported. Counter compares use `==`. The counter never wraps mid-bit.

## Structure

- Shared package/include `uart_defs`:
  - FSM state encodings (2-bit).
  - DIV/HALF computation macro, reused by `uart_tx`.
  - Frame constants (DATA_BITS=8, STOP_BITS=1).
- One sub-module, `sync_2ff`:
  - Generic 2-flop synchronizer with reset-value parameter, set to 1 here.
  - Reused for other async pins.

## Test plan

Bench parameters: CLK_FREQ=160, BAUD_RATE=10 → DIV=16, HALF=8. Bits are driven by a model `uart_tx` or a bit-bang task.

- **Single byte:** send 8'hA5 → one valid pulse, data==8'hA5, frame_err never high, busy low afterwards. Repeat with 8'h00 and 8'hFF.
- **Back-to-back:** send 8'h55 then 8'h3C with zero idle between frames → two valid pulses, 10·16 cycles apart ±1, data 8'h55 then 8'h3C.
- **False start:** rx low for 5 cycles, then high → no valid, no frame_err, busy returns to 0 within HALF+3 cycles.
- **Framing error:** send 8'h81 with stop bit driven 0 → frame_err pulse, data keeps its previous value (8'h3C), next normal frame 8'h12 → valid, data==8'h12.
- **Reset mid-frame:** drop rst_n during data bit 4 of 8'hF0 → outputs return to reset values immediately. After release, a fresh 8'h0F is received correctly.
- **Loopback:** instantiate `uart_tx` with defaults and feed 256 sequential bytes → every byte matches in order, zero frame_err.
